// File: rtl/rr_quota_arbiter.sv
// ============================================================================
// Module   : rr_quota_arbiter
// Brief    : 4-master round-robin bus arbiter with per-tenure ack quota and
//            ack-less timeout abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_quota_arbiter #(
  parameter int QUOTA   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cyc0,
  input  logic       cyc1,
  input  logic       cyc2,
  input  logic       cyc3,
  input  logic       ack,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic [1:0] gnt,
  output logic       comcyc,
  output logic       tmo,
  output logic [1:0] tmo_id
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  gnt_vec_q;
  logic [1:0]  gnt_q;
  logic [1:0]  last_q;
  logic [7:0]  ack_cnt_q;
  logic [7:0]  ack_cnt_d;
  logic [9:0]  wait_cnt_q;
  logic [9:0]  wait_cnt_d;
  logic        tmo_q;
  logic [1:0]  tmo_id_q;

  logic [3:0]  w_cyc;
  logic [1:0]  w_pick;
  logic        w_pick_valid;
  logic        w_others;
  logic        w_ack_hit;
  logic        w_quota_reach;
  logic        w_quota_end;
  logic        w_timeout;
  logic        w_release;

  assign w_cyc  = {cyc3, cyc2, cyc1, cyc0};
  assign comcyc = (state_q == BUSY) && w_cyc[gnt_q];

  // Walk k = 4 down to 1 so the candidate closest to last+1 is assigned last.
  always_comb begin
    w_pick       = 2'd0;
    w_pick_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (w_cyc[last_q + 2'(k)]) begin
        w_pick       = last_q + 2'(k);
        w_pick_valid = 1'b1;
      end
    end
  end

  assign w_others      = |(w_cyc & ~gnt_vec_q);
  assign w_ack_hit     = comcyc && ack;
  assign w_quota_reach = w_ack_hit && (({1'b0, ack_cnt_q} + 9'd1) == 9'(QUOTA));
  assign w_quota_end   = w_quota_reach && w_others;
  assign w_timeout     = comcyc && !ack && (wait_cnt_q == 10'(TIMEOUT - 1));
  assign w_release     = !w_cyc[gnt_q] || w_quota_end || w_timeout;

  always_comb begin
    ack_cnt_d  = ack_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (w_ack_hit) begin
      ack_cnt_d  = w_quota_reach ? 8'd0 : ack_cnt_q + 8'd1;
      wait_cnt_d = 10'd0;
    end else if (comcyc) begin
      wait_cnt_d = wait_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_vec_q  <= 4'd0;
      gnt_q      <= 2'd0;
      last_q     <= 2'd3;
      ack_cnt_q  <= 8'd0;
      wait_cnt_q <= 10'd0;
      tmo_q      <= 1'b0;
      tmo_id_q   <= 2'd0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ack_cnt_q  <= 8'd0;
          wait_cnt_q <= 10'd0;
          if (w_pick_valid) begin
            state_q   <= BUSY;
            gnt_q     <= w_pick;
            last_q    <= w_pick;
            gnt_vec_q <= 4'(1) << w_pick;
          end
        end
        BUSY: begin
          if (w_release) begin
            state_q    <= IDLE;
            gnt_vec_q  <= 4'd0;
            gnt_q      <= 2'd0;
            ack_cnt_q  <= 8'd0;
            wait_cnt_q <= 10'd0;
            if (w_timeout) begin
              tmo_q    <= 1'b1;
              tmo_id_q <= gnt_q;
            end
          end else begin
            ack_cnt_q  <= ack_cnt_d;
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {gnt3, gnt2, gnt1, gnt0} = gnt_vec_q;
  assign gnt    = gnt_q;
  assign tmo    = tmo_q;
  assign tmo_id = tmo_id_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_quota_arbiter.sv
// ============================================================================
// Module   : tb_rr_quota_arbiter
// Brief    : Directed and randomized checks of rr_quota_arbiter against a
//            cycle-level behavioural model of the arbitration rules.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_quota_arbiter;

  localparam int QUOTA   = 8;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cyc_v;
  logic       ack;
  logic       gnt0, gnt1, gnt2, gnt3;
  logic [1:0] gnt;
  logic       comcyc;
  logic       tmo;
  logic [1:0] tmo_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: tenure owner plus acks / ack-less cycles seen so far.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_acks;
  int m_waits;
  bit m_tmo;
  int m_tmo_id;

  logic       pre_comcyc;
  logic [3:0] pre_gv;

  rr_quota_arbiter #(.QUOTA(QUOTA), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .cyc0   (cyc_v[0]),
    .cyc1   (cyc_v[1]),
    .cyc2   (cyc_v[2]),
    .cyc3   (cyc_v[3]),
    .ack    (ack),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .gnt2   (gnt2),
    .gnt3   (gnt3),
    .gnt    (gnt),
    .comcyc (comcyc),
    .tmo    (tmo),
    .tmo_id (tmo_id)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit found;
    int id;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = 3; m_acks = 0; m_waits = 0;
      m_tmo = 0; m_tmo_id = 0;
    end else if (!m_busy) begin
      m_tmo = 0;
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        id = (m_last + k) % 4;
        if (!found && cyc_v[id]) begin
          found = 1; m_busy = 1; m_owner = id; m_last = id;
          m_acks = 0; m_waits = 0;
        end
      end
    end else begin
      m_tmo = 0;
      if (!cyc_v[m_owner]) begin
        m_busy = 0;
      end else if (ack) begin
        m_acks++;
        m_waits = 0;
        if (m_acks == QUOTA) begin
          if ((cyc_v & ~(4'(1) << m_owner)) != 4'd0) m_busy = 0;
          else m_acks = 0;
        end
      end else begin
        m_waits++;
        if (m_waits == TIMEOUT) begin
          m_busy = 0; m_tmo = 1; m_tmo_id = m_owner;
        end
      end
    end
  endtask

  // One clock: check comcyc before the edge, advance model, check registered outputs after.
  task automatic step();
    #1;
    pre_comcyc = comcyc;
    pre_gv     = {gnt3, gnt2, gnt1, gnt0};
    check_val("comcyc", comcyc, (m_busy && cyc_v[m_owner]) ? 1 : 0);
    model_update();
    @(posedge clk);
    #1;
    check_val("gnt_vec", {gnt3, gnt2, gnt1, gnt0}, m_busy ? (1 << m_owner) : 0);
    check_val("gnt",     gnt,    m_busy ? m_owner : 0);
    check_val("tmo",     tmo,    m_tmo);
    check_val("tmo_id",  tmo_id, m_tmo_id);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc_v = 4'd0; ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int grants[$];
    int acks1;
    int cc_cnt;
    int tmo_cnt;
    int hold3;
    bit dropped;
    logic [3:0] prev_gv;
    int ackp_tab[5];
    int ackp;
    int drop;

    ackp_tab = '{0, 10, 50, 90, 100};
    rst = 1'b1; cyc_v = 4'd0; ack = 1'b0;
    m_busy = 0; m_owner = 0; m_last = 3; m_acks = 0; m_waits = 0; m_tmo = 0; m_tmo_id = 0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check_val("reset_gnt_vec", {gnt3, gnt2, gnt1, gnt0}, 0);
    check_val("reset_tmo_id", tmo_id, 0);

    // All requesting, ack high: quota rotation 0,1,2,3,0
    cyc_v = 4'hF; ack = 1'b1;
    step();
    check_val("first_gnt0", gnt0, 1);
    check_val("first_gnt", gnt, 0);
    grants.push_back(gnt);
    prev_gv = {gnt3, gnt2, gnt1, gnt0};
    for (int i = 0; i < 60 && grants.size() < 5; i++) begin
      step();
      if (prev_gv == 4'd0 && {gnt3, gnt2, gnt1, gnt0} != 4'd0) grants.push_back(gnt);
      prev_gv = {gnt3, gnt2, gnt1, gnt0};
    end
    check_val("rotation_count", grants.size(), 5);
    foreach (grants[i]) check_val("rotation_order", grants[i], i % 4);

    // Quota hand-off from master 1 to master 2
    do_reset();
    cyc_v = 4'b0110; ack = 1'b1;
    acks1 = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (pre_gv[1] && pre_comcyc && ack) acks1++;
      if (i == 1)  check_val("quota_gnt1", gnt1, 1);
      if (i == 9)  check_val("quota_idle", {gnt3, gnt2, gnt1, gnt0}, 0);
      if (i == 10) check_val("quota_gnt2", gnt2, 1);
    end
    check_val("quota_acks", acks1, 8);

    // Sole requester keeps the bus past the quota
    do_reset();
    cyc_v = 4'b1000; ack = 1'b1;
    hold3 = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (gnt3) hold3++;
    end
    check_val("sole_hold", hold3, 45);

    // Timeout abort of master 2
    do_reset();
    cyc_v = 4'b0100; ack = 1'b0;
    step();
    check_val("tmo_gnt2", gnt2, 1);
    cc_cnt = 0; tmo_cnt = 0; dropped = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (!dropped && pre_comcyc) cc_cnt++;
      if (tmo) tmo_cnt++;
      if (!dropped && !gnt2) begin
        dropped = 1;
        check_val("tmo_pulse", tmo, 1);
        check_val("tmo_id_val", tmo_id, 2);
      end
    end
    check_val("tmo_dropped", dropped, 1);
    check_val("tmo_cc_cycles", cc_cnt, 64);
    check_val("tmo_pulses", tmo_cnt, 1);

    // Reset mid-tenure, then master 0 has priority again
    do_reset();
    cyc_v = 4'b0010; ack = 1'b0;
    step();
    step();
    check_val("mid_comcyc", comcyc, 1);
    cyc_v = 4'b0011; rst = 1'b1;
    step();
    check_val("mid_rst_gnt_vec", {gnt3, gnt2, gnt1, gnt0}, 0);
    check_val("mid_rst_gnt", gnt, 0);
    check_val("mid_rst_tmo", tmo, 0);
    rst = 1'b0;
    step();
    check_val("mid_regrant0", {gnt3, gnt2, gnt1, gnt0}, 4'b0001);

    // Randomized traffic against the model
    do_reset();
    for (int ph = 0; ph < 15; ph++) begin
      ackp = ackp_tab[ph % 5];
      drop = (ph % 3 == 0) ? 300 : 20;
      for (int c = 0; c < 200; c++) begin
        for (int m = 0; m < 4; m++) begin
          if (!cyc_v[m]) begin
            if ($urandom_range(0, 7) == 0) cyc_v[m] = 1'b1;
          end else if ($urandom_range(0, drop - 1) == 0) begin
            cyc_v[m] = 1'b0;
          end
        end
        ack = ($urandom_range(0, 99) < ackp);
        rst = ($urandom_range(0, 499) == 0);
        step();
      end
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_quota_arbiter.md
RR_QUOTA_ARBITER -- requirements
Module: rr_quota_arbiter

Interface
REQ-001 Parameter QUOTA, default 8, SHALL set the maximum acks per tenure while another master is requesting; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the number of consecutive ack-less owner cycles that aborts a tenure; legal range 2..1023.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 cyc3..cyc0  in  1 each  SHALL be the per-master bus-cycle requests, held high for the whole transaction.
REQ-006 ack  in  1  SHALL be the slave transfer acknowledge, meaningful only while comcyc=1.
REQ-007 gnt3..gnt0  out  1 each  SHALL be the registered one-hot grants, at most one high.
REQ-008 gnt  out  2  SHALL be the binary encoding of the granted master, 0 when no grant.
REQ-009 comcyc  out  1  SHALL be the combinational common-cycle flag: busy AND cyc of the owner.
REQ-010 tmo  out  1  SHALL be a one-cycle pulse flagging a timeout abort.
REQ-011 tmo_id  out  2  SHALL hold the id of the last timed-out master until the next abort or reset.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (one grant held).
REQ-013 In IDLE with any cyc high at edge k, the FSM SHALL enter BUSY at edge k, with the grant visible after that edge (1-cycle latency).
REQ-014 Priority SHALL be round-robin: the search SHALL start at (last+1) mod 4 and wrap; last SHALL be the 2-bit id of the previous owner.
REQ-015 last SHALL update to the new owner id on every IDLE->BUSY transition.
REQ-016 In IDLE with no cyc high, the FSM SHALL stay in IDLE, with grants 0 and counters 0.
REQ-017 In BUSY, the tenure SHALL end (BUSY->IDLE at that edge, grants 0 after it) on any of: owner cyc low; quota expiry; timeout.
REQ-018 The owner is not re-granted in that same edge; at least one IDLE cycle SHALL separate tenures.
REQ-019 ack_cnt (8 bit) SHALL increment on each cycle with comcyc=1 and ack=1, and SHALL clear on entry to BUSY.
REQ-020 Quota expiry SHALL occur when ack_cnt+ack reaches QUOTA while any non-owner cyc is high.
REQ-021 If QUOTA is reached with no other requester pending, the tenure SHALL continue and ack_cnt SHALL reset to 0.
REQ-022 wait_cnt (10 bit) SHALL increment each BUSY cycle with comcyc=1 and ack=0, SHALL clear on ack, and SHALL clear on entry to BUSY.
REQ-023 Timeout SHALL occur when wait_cnt reaches TIMEOUT-1 and ack=0.
REQ-024 On timeout, tmo SHALL pulse high for the cycle after the terminating edge, and tmo_id SHALL load the owner id.
REQ-025 If owner-release, quota and timeout coincide, the tenure SHALL end once; tmo SHALL pulse only if the timeout condition held.
REQ-026 ack while comcyc=0 SHALL be ignored.
REQ-027 Request changes by non-owners during BUSY SHALL not affect the grant.
REQ-028 Counters SHALL saturate-free wrap only through the explicit clears above; no overflow SHALL be reachable within legal parameter ranges.

Reset
REQ-029 With rst=1 at an edge: state SHALL be IDLE; gnt3..0, gnt, tmo, tmo_id and counters SHALL be 0; last SHALL be 3, so master 0 has first priority.
REQ-030 Reset asserted mid-tenure SHALL drop all grants after that edge, regardless of cyc or ack.
REQ-031 rst SHALL override every other condition in the same cycle.

Verification
REQ-032 After reset, cyc0..3 all high at edge 1 -> gnt0=1, gnt=0 after edge 1; grants then rotate 0,1,2,3,0 with one IDLE cycle between each.
REQ-033 QUOTA=8, cyc1 and cyc2 high, ack held high -> master 1 gets exactly 8 acks, then gnt drops for 1 cycle, then gnt2=1.
REQ-034 Only cyc3 high, ack always high, QUOTA=8 -> gnt3 stays high for 40+ cycles with no release.
REQ-035 TIMEOUT=64, cyc2 high, ack low -> gnt2 drops after 64 comcyc cycles; tmo=1 for exactly one cycle; tmo_id=2.
REQ-036 Reset pulsed while gnt1=1 and comcyc=1 -> all outputs 0 the next cycle; the first re-grant with cyc0 and cyc1 high goes to master 0.
